// File: rtl/pipeline_exmem_stage.sv
// EX/MEM pipeline register with data-memory request controller.
// Holds EX results, drives dmemREN/dmemWEN until dhit, and stalls the pipe while an access is outstanding.
module pipeline_exmem_stage #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              flush,
    input  logic [WORD_W-1:0] porto_in,
    input  logic [WORD_W-1:0] store_in,
    input  logic [REG_W-1:0]  wsel_in,
    input  logic              regen_in,
    input  logic [1:0]        regsrc_in,
    input  logic              dren_in,
    input  logic              dwen_in,
    input  logic              halt_in,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic [WORD_W-1:0] porto,
    output logic [REG_W-1:0]  wsel,
    output logic              regen,
    output logic [1:0]        regsrc,
    output logic              halt,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] dmemload_out,
    output logic              mem_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic              dren_l;
    logic              dwen_l;
    logic [WORD_W-1:0] dmemload_l;
    logic              in_req;
    logic              hit_now;
    logic              capture;

    // Request and stall are decoded from state so reset drops them immediately.
    assign in_req       = (state == REQ);
    assign hit_now      = in_req & dhit;
    assign mem_stall    = in_req & ~dhit;
    assign capture      = en & ~mem_stall & ~halt;
    assign dmemREN      = in_req & dren_l & ~dwen_l;
    assign dmemWEN      = in_req & dwen_l;
    assign dmemaddr     = porto;
    assign dmemload_out = hit_now ? dmemload : dmemload_l;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            porto      <= '0;
            dmemstore  <= '0;
            wsel       <= '0;
            regen      <= 1'b0;
            regsrc     <= 2'b00;
            halt       <= 1'b0;
            dren_l     <= 1'b0;
            dwen_l     <= 1'b0;
            dmemload_l <= '0;
        end else if (flush) begin
            state      <= IDLE;
            porto      <= '0;
            dmemstore  <= '0;
            wsel       <= '0;
            regen      <= 1'b0;
            regsrc     <= 2'b00;
            halt       <= 1'b0;
            dren_l     <= 1'b0;
            dwen_l     <= 1'b0;
            dmemload_l <= '0;
        end else begin
            if (hit_now) begin
                dmemload_l <= dmemload;
            end
            if (capture) begin
                porto     <= porto_in;
                dmemstore <= store_in;
                wsel      <= wsel_in;
                regen     <= regen_in;
                regsrc    <= regsrc_in;
                halt      <= halt_in;
                dren_l    <= dren_in;
                dwen_l    <= dwen_in;
                state     <= (dren_in | dwen_in) ? REQ : IDLE;
            end else if (hit_now) begin
                state <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_exmem_stage.sv
// Randomized bench for pipeline_exmem_stage against a transaction-level reference model.
module tb_pipeline_exmem_stage;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    logic              CLK = 1'b0;
    logic              RST;
    logic              en, flush, regen_in, dren_in, dwen_in, halt_in, dhit;
    logic [WORD_W-1:0] porto_in, store_in, dmemload;
    logic [REG_W-1:0]  wsel_in;
    logic [1:0]        regsrc_in;
    logic [WORD_W-1:0] porto, dmemaddr, dmemstore, dmemload_out;
    logic [REG_W-1:0]  wsel;
    logic              regen, halt, dmemREN, dmemWEN, mem_stall;
    logic [1:0]        regsrc;

    pipeline_exmem_stage #(.WORD_W(WORD_W), .REG_W(REG_W)) dut (
        .CLK(CLK), .RST(RST), .en(en), .flush(flush),
        .porto_in(porto_in), .store_in(store_in), .wsel_in(wsel_in),
        .regen_in(regen_in), .regsrc_in(regsrc_in), .dren_in(dren_in),
        .dwen_in(dwen_in), .halt_in(halt_in), .dhit(dhit), .dmemload(dmemload),
        .porto(porto), .wsel(wsel), .regen(regen), .regsrc(regsrc), .halt(halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dmemload_out(dmemload_out), .mem_stall(mem_stall)
    );

    always #5 CLK = ~CLK;

    // The latched instruction as the MEM stage sees it, plus whether its access is still owed.
    typedef struct {
        logic [31:0] porto;
        logic [31:0] store;
        logic [4:0]  wsel;
        logic        regen;
        logic [1:0]  regsrc;
        logic        dren;
        logic        dwen;
        logic        halt;
    } instr_t;

    instr_t      m_ins;
    bit          m_pending;
    logic [31:0] m_load;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic instr_t empty_instr();
        instr_t r;
        r.porto = '0; r.store = '0; r.wsel = '0; r.regen = 1'b0;
        r.regsrc = '0; r.dren = 1'b0; r.dwen = 1'b0; r.halt = 1'b0;
        return r;
    endfunction

    task automatic model_clear();
        m_ins     = empty_instr();
        m_pending = 0;
        m_load    = '0;
    endtask

    task automatic check_model();
        bit          stall_e;
        logic [31:0] load_e;
        stall_e = m_pending && !dhit;
        load_e  = (m_pending && dhit) ? dmemload : m_load;
        check("porto", porto, m_ins.porto);
        check("wsel", 32'(wsel), 32'(m_ins.wsel));
        check("regen", 32'(regen), 32'(m_ins.regen));
        check("regsrc", 32'(regsrc), 32'(m_ins.regsrc));
        check("halt", 32'(halt), 32'(m_ins.halt));
        check("dmemaddr", dmemaddr, m_ins.porto);
        check("dmemstore", dmemstore, m_ins.store);
        check("dmemREN", 32'(dmemREN), 32'(m_pending && m_ins.dren && !m_ins.dwen));
        check("dmemWEN", 32'(dmemWEN), 32'(m_pending && m_ins.dwen));
        check("mem_stall", 32'(mem_stall), 32'(stall_e));
        check("dmemload_out", dmemload_out, load_e);
    endtask

    task automatic model_edge();
        bit stall_now;
        stall_now = m_pending && !dhit;
        if (flush) begin
            model_clear();
        end else begin
            if (m_pending && dhit) m_load = dmemload;
            if (en && !stall_now && !m_ins.halt) begin
                m_ins.porto  = porto_in;  m_ins.store  = store_in;
                m_ins.wsel   = wsel_in;   m_ins.regen  = regen_in;
                m_ins.regsrc = regsrc_in; m_ins.dren   = dren_in;
                m_ins.dwen   = dwen_in;   m_ins.halt   = halt_in;
                m_pending    = dren_in || dwen_in;
            end else if (m_pending && dhit) begin
                m_pending = 0;
            end
        end
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic cycle();
        #1 check_model();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        #1;
        model_clear();
        check("rst_porto", porto, 32'h0);
        check("rst_ren", 32'(dmemREN), 32'h0);
        check("rst_wen", 32'(dmemWEN), 32'h0);
        check("rst_stall", 32'(mem_stall), 32'h0);
        check("rst_load", dmemload_out, 32'h0);
        #1 RST = 1'b0;
    endtask

    task automatic quiet();
        en = 0; flush = 0; dren_in = 0; dwen_in = 0; halt_in = 0; dhit = 0;
        regen_in = 0; regsrc_in = 0; wsel_in = 0; porto_in = 0; store_in = 0; dmemload = 0;
    endtask

    initial begin
        quiet();
        RST = 1'b1;
        model_clear();
        @(negedge CLK);
        check_model();
        RST = 1'b0;

        // Reset in the middle of an outstanding load
        en = 1; dren_in = 1; porto_in = 32'h100;
        cycle();
        quiet();
        check("pre_rst_ren", 32'(dmemREN), 32'h1);
        pulse_reset();
        cycle();

        // Load with a delayed hit, pipeline advancing on the hit cycle
        en = 1; dren_in = 1; porto_in = 32'h40; wsel_in = 5; regen_in = 1; regsrc_in = 2'b01;
        cycle();
        check("ld_ren", 32'(dmemREN), 32'h1);
        check("ld_addr", dmemaddr, 32'h40);
        check("ld_stall", 32'(mem_stall), 32'h1);
        for (int i = 0; i < 3; i++) begin
            porto_in = $urandom; wsel_in = 5'($urandom); dren_in = 0;
            cycle();
            check("hold_porto", porto, 32'h40);
            check("hold_wsel", 32'(wsel), 32'd5);
        end
        dhit = 1; dmemload = 32'hDEADBEEF; porto_in = 0; wsel_in = 0;
        #1;
        check("hit_stall", 32'(mem_stall), 32'h0);
        check("hit_load", dmemload_out, 32'hDEADBEEF);
        cycle();
        dhit = 0; en = 0;
        #1 check("after_hit_ren", 32'(dmemREN), 32'h0);
        @(negedge CLK);

        // Store, hit while en is low -> waits in DONE with fields held
        quiet();
        en = 1; dwen_in = 1; store_in = 32'h12345678; porto_in = 32'h200;
        cycle();
        quiet();
        check("st_wen", 32'(dmemWEN), 32'h1);
        check("st_data", dmemstore, 32'h12345678);
        cycle();
        dhit = 1;
        cycle();
        dhit = 0;
        check("done_wen", 32'(dmemWEN), 32'h0);
        check("done_stall", 32'(mem_stall), 32'h0);
        check("done_store", dmemstore, 32'h12345678);
        cycle();

        // Flush abandons an outstanding load; a late hit is ignored
        en = 1; dren_in = 1; porto_in = 32'h80;
        cycle();
        quiet();
        flush = 1;
        cycle();
        flush = 0;
        check("fl_porto", porto, 32'h0);
        check("fl_ren", 32'(dmemREN), 32'h0);
        dhit = 1; dmemload = 32'h55;
        cycle();
        check("fl_load", dmemload_out, 32'h0);
        dhit = 0;

        // Load+store together: store wins; then a plain ALU op
        en = 1; dren_in = 1; dwen_in = 1; porto_in = 32'h300;
        cycle();
        check("both_wen", 32'(dmemWEN), 32'h1);
        check("both_ren", 32'(dmemREN), 32'h0);
        dhit = 1; dren_in = 0; dwen_in = 0; porto_in = 32'h1234; regen_in = 1;
        cycle();
        dhit = 0;
        check("alu_porto", porto, 32'h1234);
        check("alu_stall", 32'(mem_stall), 32'h0);
        check("alu_req", 32'({dmemREN, dmemWEN}), 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 6);
            dhit      = ($urandom_range(0, 99) < 35);
            halt_in   = ($urandom_range(0, 99) < 3);
            dren_in   = ($urandom_range(0, 99) < 35);
            dwen_in   = ($urandom_range(0, 99) < 25);
            regen_in  = 1'($urandom);
            regsrc_in = 2'($urandom);
            wsel_in   = 5'($urandom);
            porto_in  = $urandom;
            store_in  = $urandom;
            dmemload  = $urandom;
            if ($urandom_range(0, 99) == 0) pulse_reset();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_exmem_stage.md
Name: pipeline_exmem_stage

Overview:
- EX/MEM pipeline register plus data-memory request controller for the 5-stage MIPS pipeline.
- Captures EX-stage results and control, and drives dmemREN/dmemWEN to the data cache until dhit.
- Raises a stall to the hazard unit while a memory access is outstanding.
- Presents porto, wsel, regen, regsrc and dmemload to the downstream MEM/WB latch.

Parameters:
- WORD_W, 32, datapath word width
- REG_W, 5, register select width

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous active-high reset
- en  input  1  pipeline advance from hazard unit
- flush  input  1  insert bubble into EX/MEM
- porto_in  input  WORD_W  ALU result, also the memory address
- store_in  input  WORD_W  rt data for stores
- wsel_in  input  REG_W  destination register
- regen_in  input  1  register write enable
- regsrc_in  input  2  writeback source select
- dren_in  input  1  instruction is a load
- dwen_in  input  1  instruction is a store
- halt_in  input  1  halt instruction
- dhit  input  1  cache access complete
- dmemload  input  WORD_W  cache read data
- porto  output  WORD_W  latched ALU result
- wsel  output  REG_W  latched destination
- regen  output  1  latched register write enable
- regsrc  output  2  latched writeback source
- halt  output  1  latched halt
- dmemREN  output  1  cache read request
- dmemWEN  output  1  cache write request
- dmemaddr  output  WORD_W  equals porto
- dmemstore  output  WORD_W  latched store data
- dmemload_out  output  WORD_W  load data to MEM/WB
- mem_stall  output  1  stall request to hazard unit

Behaviour:
- Reset (async, immediate):
  - All latched fields and dmemload_out are 0.
  - FSM goes to IDLE, so dmemREN, dmemWEN and mem_stall are 0 immediately, including mid-request.
- FSM states: IDLE (no access pending), REQ (access outstanding), DONE (access complete, waiting for advance).
- Capture condition: en=1 and mem_stall=0.
  - All *_in fields load on the rising edge.
  - Next state is REQ if dren_in or dwen_in is set, otherwise IDLE.
  - Latency: EX inputs to outputs is 1 cycle.
- en while mem_stall=1 is ignored; all fields hold.
- flush has priority over en and every FSM state:
  - Next edge, all fields clear to 0 (bubble) and the FSM goes to IDLE.
  - An outstanding request is abandoned. Requests are deasserted from that edge.
- REQ:
  - dmemREN = dren_l & ~dwen_l.
  - dmemWEN = dwen_l.
  - If both dren and dwen are latched, the store wins.
- mem_stall = (state==REQ) & ~dhit. This lets the hazard unit advance in the same cycle dhit arrives.
- On dhit in REQ:
  - The internal dmemload_l register captures dmemload.
  - If en=1, a new capture occurs on the same edge (to REQ or IDLE). Otherwise the next state is DONE.
- dmemload_out = (state==REQ & dhit) ? dmemload : dmemload_l. MEM/WB therefore sees valid load data on the advancing edge.
- DONE: requests are 0 and mem_stall is 0. en=1 captures as above.
- dhit in IDLE or DONE is ignored.
- halt latch: once halt=1, the block does not capture non-flush inputs. Only RST or flush clears it.
- No arithmetic; widths pass through unchanged. dmemaddr is combinational from porto.

Test Plan:
- Reset mid-REQ: lw latched, RST pulsed before dhit -> dmemREN drops in the same cycle, all outputs 0, mem_stall 0.
- Load, delayed hit: en=1, dren_in=1, porto_in=0x00000040, wsel_in=5 -> next cycle dmemREN=1, dmemaddr=0x40, mem_stall=1. 3 cycles later dhit=1 with dmemload=0xDEADBEEF and en=1 -> same cycle mem_stall=0 and dmemload_out=0xDEADBEEF; next edge dmemREN=0.
- Store, hit, en low: dwen_in=1, store_in=0x12345678 -> dmemWEN=1 and dmemstore=0x12345678 until dhit. dhit with en=0 -> DONE, dmemWEN=0, mem_stall=0, fields held.
- Stall hold: en=1 while REQ without dhit, changing *_in values -> porto and wsel unchanged, no new capture.
- Flush during REQ: flush=1 -> next edge all fields 0, dmemREN=0, state IDLE. A later dhit is ignored.
- Both dren_in and dwen_in set -> dmemWEN=1, dmemREN=0. A non-memory instruction (addu) -> no request, mem_stall stays 0, porto valid after 1 cycle.
